// File: rtl/cache_pkg.sv
// Shared definitions for the 4-word-block spatial cache and its refill path.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      COMMIT
   } state_t;

   localparam int WORDS_PER_BLOCK   = 4;
   localparam int BLOCK_OFFSET_BITS = 4;
   localparam int WORD_BYTES        = 4;

endpackage

// File: rtl/refill_buffer.sv
// Four-word staging buffer for a block refill, written one beat at a time.
// The read view forwards a word being written this cycle so the last beat is visible at once.
module refill_buffer
   import cache_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [1:0]            wr_idx,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_words [WORDS_PER_BLOCK]
);

   logic [DATA_WIDTH-1:0] words [WORDS_PER_BLOCK];

   // NOTE: this array is cleared on rst on purpose; stale words from an aborted refill must never surface.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < WORDS_PER_BLOCK; i++) words[i] <= '0;
      end else if (wr_en) begin
         words[wr_idx] <= wr_data;
      end
   end

   // NOTE: every element is assigned on every pass, so no latch can be inferred here.
   always_comb begin
      for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
         rd_words[i] = (wr_en && wr_idx == 2'(i)) ? wr_data : words[i];
      end
   end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss handler: stalls the CPU, fetches the missed 4-word block one beat per
// memory handshake, then strobes the assembled block into the cache for one cycle.
module cache_refill_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  cache_hit,
   output logic                  stall,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_rvalid,
   output logic                  fill_we,
   output logic [ADDR_WIDTH-1:0] fill_addr,
   output logic [DATA_WIDTH-1:0] fill_data0,
   output logic [DATA_WIDTH-1:0] fill_data1,
   output logic [DATA_WIDTH-1:0] fill_data2,
   output logic [DATA_WIDTH-1:0] fill_data3
);

   localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << BLOCK_OFFSET_BITS) - 1);

   state_t                state;
   logic [1:0]            beat;
   logic [ADDR_WIDTH-1:0] base;
   logic [ADDR_WIDTH-1:0] miss_base;
   logic                  miss;
   logic                  capture;
   logic [DATA_WIDTH-1:0] block_words [WORDS_PER_BLOCK];

   assign miss      = req_valid & ~cache_hit;
   assign miss_base = req_addr & ~OFFSET_MASK;
   // Data arriving without an outstanding request is dropped here.
   assign capture   = (state == FETCH) & mem_rvalid;
   assign stall     = (state == IDLE) ? miss : 1'b1;

   refill_buffer #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_refill_buffer (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (capture),
      .wr_idx  (beat),
      .wr_data (mem_rdata),
      .rd_words(block_words)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         beat       <= '0;
         base       <= '0;
         mem_rd_en  <= 1'b0;
         mem_addr   <= '0;
         fill_we    <= 1'b0;
         fill_addr  <= '0;
         fill_data0 <= '0;
         fill_data1 <= '0;
         fill_data2 <= '0;
         fill_data3 <= '0;
      end else begin
         fill_we <= 1'b0;
         case (state)
            IDLE: begin
               if (miss) begin
                  base      <= miss_base;
                  mem_addr  <= miss_base;
                  beat      <= '0;
                  mem_rd_en <= 1'b1;
                  state     <= FETCH;
               end
            end
            FETCH: begin
               if (mem_rvalid) begin
                  if (beat == 2'd3) begin
                     // The final beat is forwarded by the buffer, so the block is complete now.
                     mem_rd_en  <= 1'b0;
                     fill_we    <= 1'b1;
                     fill_addr  <= base;
                     fill_data0 <= block_words[0];
                     fill_data1 <= block_words[1];
                     fill_data2 <= block_words[2];
                     fill_data3 <= block_words[3];
                     state      <= COMMIT;
                  end else begin
                     beat     <= beat + 2'd1;
                     mem_addr <= mem_addr + ADDR_WIDTH'(WORD_BYTES);
                  end
               end
            end
            COMMIT:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Miss-handling stage that sits directly upstream of the 4-word-block spatial cache.
- On a cache miss it stalls the CPU and fetches the 4-word block containing the missed address from main memory, one word per handshake.
- It then pulses the cache's overwrite/write strobe with the assembled block and releases the stall once the cache reports a hit.

Parameters:
- ADDR_WIDTH, 32, byte-address width of CPU and memory addresses.
- DATA_WIDTH, 32, word width. Block size is fixed at 4 words (16 bytes).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  CPU has a valid access this cycle
- req_addr  in  ADDR_WIDTH  CPU byte address
- cache_hit  in  1  hit indication from the cache for req_addr
- stall  out  1  hold the CPU pipeline
- mem_rd_en  out  1  memory read request, held until accepted
- mem_addr  out  ADDR_WIDTH  word-aligned memory read address
- mem_rdata  in  DATA_WIDTH  memory read data
- mem_rvalid  in  1  mem_rdata valid; completes the current request
- fill_we  out  1  one-cycle write strobe to the cache (drives its overwrite)
- fill_addr  out  ADDR_WIDTH  block base address for the cache tag/set
- fill_data0..fill_data3  out  DATA_WIDTH each  block words at offsets 0, 4, 8, 12

Behaviour:
- Reset values: state IDLE, beat counter 0, stall 0, mem_rd_en 0, mem_addr 0, fill_we 0, fill_addr 0, fill_data0..3 0.
- The block base is latched as req_addr with bits [3:0] cleared.
- States:
  - IDLE:
    - stall = req_valid & ~cache_hit (combinational).
    - If req_valid & ~cache_hit: latch the base, set beat = 0, go to FETCH.
  - FETCH:
    - stall = 1 and mem_rd_en = 1.
    - mem_addr = base + 4*beat, registered and stable while waiting.
    - On mem_rvalid: capture mem_rdata into word[beat].
    - If beat == 3, go to COMMIT; otherwise increment beat.
  - COMMIT:
    - stall = 1, fill_we = 1 for exactly one cycle.
    - fill_addr = base; fill_data0..3 = captured words.
    - Go to IDLE.
- Memory handshake:
  - One request outstanding at a time.
  - Zero-wait memory is legal: rvalid may arrive in the same cycle rd_en rises, giving 1 cycle per beat.
  - mem_rvalid while mem_rd_en = 0 is ignored.
- Latency: miss to fill_we = 4 beats + 1 cycle. With zero-wait memory, fill_we is asserted in cycle 5 after miss detection (cycle 0).
- The first cycle back in IDLE re-evaluates the hit; the cache has been written by then, so stall drops.
- req_valid dropping or req_addr changing during FETCH/COMMIT does not affect the refill, because the address is latched.
- cache_hit is ignored outside IDLE.
- Unaligned req_addr (any value in [3:0]) maps to the same base; the whole block is always fetched starting at offset 0.
- Back-to-back misses: after COMMIT, if the next request in IDLE also misses, a new refill starts immediately.
- fill_data0..3 and fill_addr hold their last values after COMMIT. Only fill_we qualifies them.
- rst mid-refill: next cycle in IDLE; mem_rd_en, fill_we and stall go to 0; partial words are discarded and no fill_we is issued. Any late mem_rvalid is ignored.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. The beat counter is 2 bits.

Decomposition:
- Shared package cache_pkg:
  - State enum {IDLE, FETCH, COMMIT}.
  - Constants WORDS_PER_BLOCK = 4, BLOCK_OFFSET_BITS = 4, WORD_BYTES = 4.
  - Also used by the cache itself.
- One sub-module, refill_buffer: a 4×DATA_WIDTH register file written by beat index on capture and cleared on rst. The FSM and address generation stay in the top.

Test Plan:
- Hit: req_valid = 1, cache_hit = 1, addr 0x200 -> stall = 0; mem_rd_en never asserted.
- Miss, zero-wait memory: miss at 0x104 -> mem_addr sequence 0x100, 0x104, 0x108, 0x10C on consecutive cycles; fill_we is a single pulse in cycle 5 with fill_addr = 0x100 and fill_data = returned words; stall deasserts once cache_hit = 1.
- Miss, 2-cycle-wait memory: each mem_addr held 3 cycles until rvalid -> fill_we at cycle 13; stall held high throughout.
- Reset during beat 2 -> next cycle: stall = 0, mem_rd_en = 0, no fill_we. A subsequent miss at 0x300 refetches from 0x300.
- Spurious mem_rvalid in IDLE with data 0xDEADBEEF -> ignored; a following refill's fill_data contains no 0xDEADBEEF.
- Back-to-back misses at 0x10C then 0x410, with req_addr changed mid-FETCH -> first fill_addr = 0x100 unaffected, second fill_addr = 0x410, with no idle gap beyond the IDLE evaluation cycle.
